// File: rtl/tt_gate_tester.sv
// Self-test sequencer for two-input gate tiles: walks A/B through all four vectors and checks Y.
// Optional GATE_TESTER_LOOP_EN: keep running back-to-back while start is held, accumulating results.
module tt_gate_tester #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  EXPECT        = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_y,
    output logic       drv_a,
    output logic       drv_b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [7:0] fail_cnt
);

    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("tt_gate_tester: SETTLE_CYCLES must be in 2..255");
    end

    localparam logic [7:0] CntLoad = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       sync1;
    logic       y_s;
    logic       mismatch;
    logic [1:0] vec_nxt;
    logic [3:0] mask_nxt;
    logic [7:0] cnt_nxt;

    // Gate output is asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            y_s   <= 1'b0;
        end else begin
            sync1 <= dut_y;
            y_s   <= sync1;
        end
    end

    always_comb begin
        mismatch = (y_s != EXPECT[vec_idx]);
        vec_nxt  = vec_idx + 2'd1;
        mask_nxt = fail_mask;
        cnt_nxt  = fail_cnt;
        if (mismatch) begin
            mask_nxt = fail_mask | (4'b0001 << vec_idx);
            if (fail_cnt != 8'hff) begin
                cnt_nxt = fail_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= 8'd0;
            vec_idx   <= 2'd0;
            drv_a     <= 1'b0;
            drv_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            fail_cnt  <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StSettle;
                        cnt       <= CntLoad;
                        vec_idx   <= 2'd0;
                        drv_a     <= 1'b0;
                        drv_b     <= 1'b0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail_mask <= 4'd0;
                        fail_cnt  <= 8'd0;
                    end
                end
                StSettle: begin
                    if (cnt == 8'd0) begin
                        state <= StSample;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                StSample: begin
                    fail_mask <= mask_nxt;
                    fail_cnt  <= cnt_nxt;
                    if (vec_idx != 2'd3) begin
                        state   <= StSettle;
                        cnt     <= CntLoad;
                        vec_idx <= vec_nxt;
                        drv_a   <= vec_nxt[0];
                        drv_b   <= vec_nxt[1];
                    end else begin
                        done    <= 1'b1;
                        pass    <= (mask_nxt == 4'd0);
                        vec_idx <= 2'd0;
                        drv_a   <= 1'b0;
                        drv_b   <= 1'b0;
`ifdef GATE_TESTER_LOOP_EN
                        // The done cycle doubles as the first settle cycle of the next run.
                        if (start) begin
                            state <= StSettle;
                            cnt   <= CntLoad;
                        end else begin
                            state <= StDone;
                            busy  <= 1'b0;
                        end
`else
                        state <= StDone;
                        busy  <= 1'b0;
`endif
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_gate_tester.sv
// Directed bench for tt_gate_tester (default build, SETTLE_CYCLES=4, EXPECT=NAND).
module tb_tt_gate_tester;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dut_y;
    logic       drv_a;
    logic       drv_b;
    logic [1:0] vec_idx;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [7:0] fail_cnt;

    logic [3:0] model;  // truth table of the emulated gate, indexed by {B,A}
    int checks   = 0;
    int failures = 0;

    assign dut_y = model[{drv_b, drv_a}];

    always #5 clk = ~clk;

    tt_gate_tester dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dut_y     (dut_y),
        .drv_a     (drv_a),
        .drv_b     (drv_b),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .fail_cnt  (fail_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".pass"}, pass, 0);
        chk({tag, ".mask"}, fail_mask, 0);
        chk({tag, ".cnt"}, fail_cnt, 0);
        chk({tag, ".vec"}, vec_idx, 0);
        chk({tag, ".drv_a"}, drv_a, 0);
        chk({tag, ".drv_b"}, drv_b, 0);
    endtask

    // Starts a run (current cycle becomes cycle 0) and checks cycles 1..30.
    // S=4 so vector slots are 5 cycles: busy in 1..20, done only in 21.
    task automatic run(input logic [3:0] em, input logic [7:0] ec, input logic ep,
                       input int repulse);
        int v;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 30; c++) begin
            start = (c == repulse);
            v = (c - 1) / 5;
            chk($sformatf("busy@%0d", c), busy, (c <= 20) ? 1 : 0);
            chk($sformatf("done@%0d", c), done, (c == 21) ? 1 : 0);
            chk($sformatf("vec@%0d", c), vec_idx, (c <= 20) ? v : 0);
            chk($sformatf("drv_a@%0d", c), drv_a, (c <= 20) ? (v & 1) : 0);
            chk($sformatf("drv_b@%0d", c), drv_b, (c <= 20) ? ((v >> 1) & 1) : 0);
            if (c == 1) begin
                chk("start.pass", pass, 0);
                chk("start.mask", fail_mask, 0);
                chk("start.cnt", fail_cnt, 0);
            end
            if (c == 21 || c == 30) begin
                chk($sformatf("mask@%0d", c), fail_mask, em);
                chk($sformatf("cnt@%0d", c), fail_cnt, ec);
                chk($sformatf("pass@%0d", c), pass, ep);
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        model = 4'b0111;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk_all_zero("idle");

        // Ideal NAND.
        run(4'b0000, 8'd0, 1'b1, 0);

        // Y stuck high: only vector 3 (A=B=1) mismatches.
        model = 4'b1111;
        run(4'b1000, 8'd1, 1'b0, 0);

        // AND gate: every vector mismatches; a NAND run afterwards clears the results.
        model = 4'b1000;
        run(4'b1111, 8'd4, 1'b0, 0);
        model = 4'b0111;
        run(4'b0000, 8'd0, 1'b1, 0);

        // Reset asserted in cycle 8 of a run.
        model = 4'b1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        chk("pre_abort.busy", busy, 1);
        chk("pre_abort.mask", fail_mask, 4'b0001);
        rst = 1'b1;
        tick();
        chk_all_zero("abort");
        rst = 1'b0;
        for (int c = 10; c <= 25; c++) begin
            chk($sformatf("abort.done@%0d", c), done, 0);
            chk($sformatf("abort.busy@%0d", c), busy, 0);
            tick();
        end
        model = 4'b0111;
        run(4'b0000, 8'd0, 1'b1, 0);

        // start re-pulsed mid-run is ignored; no second run follows.
        model = 4'b1111;
        run(4'b1000, 8'd1, 1'b0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_gate_tester.md
# tt_gate_tester

Self-test sequencer for the two-input gate tiles: drives the gate's A/B input pins through all four truth-table vectors, waits a settle time, samples the gate's Y output pin and compares it against an expected truth table. It sits on the opposite side of the tile's pin interface (driving `ui_in[1:0]`, reading `uo_out[0]`) and reports a per-vector fail mask, a fail count and a pass flag.

## Interface

Parameters:
- `SETTLE_CYCLES`, 4: wait cycles per vector before sampling; legal range 2..255, elaboration error outside it.
- `EXPECT`, 4'b0111: expected Y per vector; bit i is the expected value for vector i = {B,A}. The default is NAND.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled in IDLE to begin a run.
- `dut_y`  in  1  gate output pin; asynchronous to `clk`.
- `drv_a`  out  1  drives gate input A (vector bit 0).
- `drv_b`  out  1  drives gate input B (vector bit 1).
- `vec_idx`  out  2  index of the vector currently driven.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  high when the last completed run had no mismatches.
- `fail_mask`  out  4  bit i set if vector i mismatched.
- `fail_cnt`  out  8  saturating count of mismatching samples.

## Operation

- `dut_y` passes through a 2-flop synchronizer before any use; its output is `y_s`.
- FSM states:
  - IDLE: `drv_a`/`drv_b` = 0, `busy` = 0.
  - SETTLE: the down-counter is loaded with `SETTLE_CYCLES`−1 on entry.
  - SAMPLE.
  - DONE.
- IDLE -> SETTLE when `start`=1. Entry sets `vec_idx`=0, clears `fail_mask` and `fail_cnt`, and clears `pass`.
- SETTLE -> SAMPLE when the counter reaches 0.
- SAMPLE: compare `y_s` with `EXPECT[vec_idx]`. On mismatch, set `fail_mask[vec_idx]` and increment `fail_cnt`; the counter saturates at 255.
- SAMPLE -> SETTLE with `vec_idx`+1 if `vec_idx`<3. Otherwise SAMPLE -> DONE.
- DONE: pulse `done` and set `pass` = (`fail_mask`==0, including the final sample). Then go to IDLE.
- `drv_a`/`drv_b` always equal `vec_idx[0]`/`vec_idx[1]` while `busy`. They hold constant across each vector slot.
- `start` is ignored while busy.
- `fail_mask`, `fail_cnt` and `pass` hold after DONE until the next run begins or `rst` is asserted.
- Reset values: all outputs 0; FSM in IDLE; synchronizer flops 0.
- `rst` mid-run aborts immediately:
  - next cycle all outputs are 0;
  - no `done` pulse;
  - results are lost.

## Timing

- Cycle 0 is the edge where `start`=1 is sampled in IDLE.
- Each vector slot is `SETTLE_CYCLES`+1 cycles: `SETTLE_CYCLES` cycles of SETTLE, then 1 SAMPLE cycle.
- Vector v is driven in cycles 1+v·(S+1) through (v+1)·(S+1), where S = `SETTLE_CYCLES`.
- `busy` is high in cycles 1..4·(S+1).
- `done` is high only in cycle 4·(S+1)+1. In that cycle `busy`=0 and the results are final.
- Sample latency: the value compared reflects `dut_y` from 2 cycles before SAMPLE. With S≥2 it is never older than the current vector's first driven cycle.
- A new run can start at the earliest in the cycle after `done`. Holding `start` high gives back-to-back runs with one idle cycle between them.

## Configuration

- `GATE_TESTER_LOOP_EN` defined:
  - From DONE the FSM returns directly to SETTLE with `vec_idx`=0 if `start` is still high; there is no idle cycle.
  - `busy` stays high across runs, and `done` pulses once per run.
  - `fail_mask` and `fail_cnt` accumulate across looped runs. They clear only on `rst` or on a fresh start from IDLE.
  - `pass` updates at every DONE from the accumulated mask.
- Not defined: single-shot behaviour exactly as in Operation.

## Test plan

- Ideal NAND model on `dut_y`, S=4, `start` pulsed at cycle 0 -> `done` in cycle 21 only, `busy` high in cycles 1..20, `pass`=1, `fail_mask`=4'b0000, `fail_cnt`=0.
- `dut_y` stuck at 1 -> `fail_mask`=4'b1000, `fail_cnt`=1, `pass`=0.
- AND model (inverted gate) -> `fail_mask`=4'b1111, `fail_cnt`=4, `pass`=0. A following run with the NAND model clears these to 0/0/1.
- `rst` asserted in cycle 8 of a run -> from cycle 9 all outputs are 0 and no `done` pulse occurs. A `start` afterwards runs cleanly.
- `start` re-pulsed in cycle 5 of a run -> ignored: `done` still occurs only in cycle 21, and no second run follows.
- With `GATE_TESTER_LOOP_EN`, `start` held high, AND model -> `done` pulses at cycles 21, 41 and 61, `busy` stays high continuously, and `fail_cnt` reads 4, 8 and 12 at those pulses.
